// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared opcode constants and FSM state type for seq_alu.
package seq_alu_pkg;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_PADD = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
endpackage

// File: rtl/seq_alu_mul_seq.sv
// mul_seq: W-iteration shift-add unsigned multiplier.
// Ports: clk, rst (async high), start (load operands when not busy),
//        a/b operands, busy (iterating), done (final iteration happens at
//        this edge), product (2W-bit result, valid while done is high).
module mul_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [2*W-1:0] mcand, acc, acc_nxt;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  // The product is exposed combinationally so the parent can latch it on the
  // same edge that performs the last iteration.
  assign done    = busy && (cnt == '0);
  assign product = acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start && !busy) begin
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(W - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: small sequential ALU. ADD/SUB/PADD finish in one cycle, MUL runs
// a W-iteration shift-add multiplier.
// Ports: clk, rst (async high), start/ready handshake, a/b operands,
//        control_sig opcode, res (low W bits), res_hi (MUL high bits),
//        overflow flag, done (one-cycle pulse when results are valid).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int PART_LEN = 8,
  parameter int PARTS    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      ready,
  input  logic [PARTS*PART_LEN-1:0] a,
  input  logic [PARTS*PART_LEN-1:0] b,
  input  logic [1:0]                control_sig,
  output logic [PARTS*PART_LEN-1:0] res,
  output logic [PARTS*PART_LEN-1:0] res_hi,
  output logic                      overflow,
  output logic                      done
);
  localparam int W = PARTS * PART_LEN;

  state_t state, state_nxt;
  logic   accept, mul_start, mul_busy, mul_done;
  logic [2*W-1:0] mul_prod;
  logic [W:0]     add_sum, sub_diff;
  logic [W-1:0]   padd_res;
  logic [PARTS-1:0] padd_cy;

  assign add_sum  = {1'b0, a} + {1'b0, b};
  // Top bit of the extended difference is the unsigned borrow (a < b).
  assign sub_diff = {1'b0, a} - {1'b0, b};

  // Independent lanes: carries are dropped at each lane boundary.
  for (genvar g = 0; g < PARTS; g++) begin : g_lane
    logic [PART_LEN:0] sum;
    assign sum = {1'b0, a[g*PART_LEN +: PART_LEN]} + {1'b0, b[g*PART_LEN +: PART_LEN]};
    assign padd_res[g*PART_LEN +: PART_LEN] = sum[PART_LEN-1:0];
    assign padd_cy[g] = sum[PART_LEN];
  end

  assign accept    = start && ready;
  assign mul_start = accept && (control_sig == OP_MUL);

  mul_seq #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = !mul_busy;
        if (start && !mul_busy)
          state_nxt = (control_sig == OP_MUL) ? MUL : DONE;
      end
      MUL:     if (mul_done) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      res      <= '0;
      res_hi   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        case (control_sig)
          OP_ADD:  begin res <= add_sum[W-1:0];  res_hi <= '0; overflow <= add_sum[W];  end
          OP_SUB:  begin res <= sub_diff[W-1:0]; res_hi <= '0; overflow <= sub_diff[W]; end
          OP_PADD: begin res <= padd_res;        res_hi <= '0; overflow <= |padd_cy;    end
          default: ; // MUL: previous result stays visible while iterating
        endcase
      end
      if (mul_done && state == MUL) begin
        res      <= mul_prod[W-1:0];
        res_hi   <= mul_prod[2*W-1:W];
        overflow <= |mul_prod[2*W-1:W];
      end
    end
  end
endmodule
